pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/pipeline_fwd_unit.sv | 21 ++
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 8-bit, 4-register pipeline hazard logic.
package pipeline_pkg;
  localparam int REG_AW = 2;
  localparam int DW     = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef logic [DW-1:0] data_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_HALT
  } hz_state_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic bubble_ex;
    logic flush_ifid;
    logic flush_idex;
    logic bubble_wb;
  } hz_ctrl_t;
endpackage

// File: rtl/pipeline_fwd_unit.sv
// Operand forwarding select for one EX source register; EX/MEM ALU result wins over MEM/WB.
module pipeline_fwd_unit
  import pipeline_pkg::*;
(
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic              i_exmem_reg_en,
  input  logic              i_exmem_is_load,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic              i_memwb_reg_en,
  output logic [1:0]        o_sel
);
  // A load in MEM has no data yet, so it can only be forwarded once it reaches WB.
  always_comb begin
    o_sel = FWD_RF;
    if (i_exmem_reg_en && !i_exmem_is_load && (i_exmem_rd == i_rs))
      o_sel = FWD_MEM;
    else if (i_memwb_reg_en && (i_memwb_rd == i_rs))
      o_sel = FWD_WB;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/forward controller with a memory-wait freeze FSM.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating performance counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_ifid_rs1,
  input  logic [REG_AW-1:0] i_ifid_rs2,
  input  logic              i_ifid_use_rs1,
  input  logic              i_ifid_use_rs2,
  input  logic [REG_AW-1:0] i_idex_rs1,
  input  logic [REG_AW-1:0] i_idex_rs2,
  input  logic [REG_AW-1:0] i_idex_rd,
  input  logic              i_idex_reg_en,
  input  logic              i_idex_is_load,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic              i_exmem_reg_en,
  input  logic              i_exmem_is_load,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic              i_memwb_reg_en,
  input  logic              i_dm_req,
  input  logic              i_dm_ready,
  input  logic              i_br_taken,
  output logic              o_stall_if,
  output logic              o_stall_id,
  output logic              o_stall_ex,
  output logic              o_stall_mem,
  output logic              o_bubble_ex,
  output logic              o_flush_ifid,
  output logic              o_flush_idex,
  output logic              o_bubble_wb,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic              o_mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_perf_stall_cnt,
  output logic [CNT_W-1:0]  o_perf_flush_cnt,
  output logic [CNT_W-1:0]  o_perf_wait_cnt
`endif
);
  hz_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic             r_br_pend, r_mem_err;
  logic             w_dm_stall, w_freeze, w_flush, w_ld_use;
  hz_ctrl_t         w_ctrl;
  logic [1:0]       w_fwd_a, w_fwd_b;

  assign w_dm_stall = i_dm_req && !i_dm_ready;
  // The cycle dm_ready rises in MEM_WAIT is not frozen: the returning data must advance.
  assign w_freeze = (r_state == ST_HALT) ||
                    ((r_state == ST_MEM_WAIT) && !i_dm_ready) ||
                    ((r_state == ST_RUN) && w_dm_stall);
  assign w_flush  = i_br_taken || r_br_pend;
  assign w_ld_use = i_idex_is_load && i_idex_reg_en &&
                    ((i_ifid_use_rs1 && (i_ifid_rs1 == i_idex_rd)) ||
                     (i_ifid_use_rs2 && (i_ifid_rs2 == i_idex_rd)));

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = '0;
    case (r_state)
      ST_RUN:      if (w_dm_stall) w_state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (i_dm_ready)
          w_state_nxt = ST_RUN;
        else if (r_wait_cnt == CNT_W'(WAIT_TIMEOUT - 1))
          w_state_nxt = ST_HALT;
        else
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
      end
      ST_HALT:     w_state_nxt = ST_HALT;
      default:     w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_br_pend  <= 1'b0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= r_mem_err || (w_state_nxt == ST_HALT);
      if (w_freeze && i_br_taken) r_br_pend <= 1'b1;
      else if (!w_freeze)         r_br_pend <= 1'b0;
    end
  end

  always_comb begin
    w_ctrl = '0;
    if (w_freeze) begin
      w_ctrl.stall_if  = 1'b1;
      w_ctrl.stall_id  = 1'b1;
      w_ctrl.stall_ex  = 1'b1;
      w_ctrl.stall_mem = 1'b1;
      w_ctrl.bubble_wb = 1'b1;
    end else if (w_flush) begin
      w_ctrl.flush_ifid = 1'b1;
      w_ctrl.flush_idex = 1'b1;
    end else if (w_ld_use) begin
      w_ctrl.stall_if  = 1'b1;
      w_ctrl.stall_id  = 1'b1;
      w_ctrl.bubble_ex = 1'b1;
    end
  end

  pipeline_fwd_unit u_fwd_a (
    .i_rs(i_idex_rs1), .i_exmem_rd(i_exmem_rd), .i_exmem_reg_en(i_exmem_reg_en),
    .i_exmem_is_load(i_exmem_is_load), .i_memwb_rd(i_memwb_rd),
    .i_memwb_reg_en(i_memwb_reg_en), .o_sel(w_fwd_a)
  );
  pipeline_fwd_unit u_fwd_b (
    .i_rs(i_idex_rs2), .i_exmem_rd(i_exmem_rd), .i_exmem_reg_en(i_exmem_reg_en),
    .i_exmem_is_load(i_exmem_is_load), .i_memwb_rd(i_memwb_rd),
    .i_memwb_reg_en(i_memwb_reg_en), .o_sel(w_fwd_b)
  );

  // Reset is synchronous, so outputs are gated to keep them quiet for the whole reset cycle.
  assign {o_stall_if, o_stall_id, o_stall_ex, o_stall_mem,
          o_bubble_ex, o_flush_ifid, o_flush_idex, o_bubble_wb} = rst ? '0 : w_ctrl;
  assign o_fwd_a   = rst ? FWD_RF : w_fwd_a;
  assign o_fwd_b   = rst ? FWD_RF : w_fwd_b;
  assign o_mem_err = !rst && r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_stall, r_perf_flush, r_perf_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
      r_perf_wait  <= '0;
    end else begin
      if (w_ctrl.bubble_ex && !(&r_perf_stall))    r_perf_stall <= r_perf_stall + 1'b1;
      if (w_ctrl.flush_ifid && !(&r_perf_flush))   r_perf_flush <= r_perf_flush + 1'b1;
      if ((r_state == ST_MEM_WAIT) && !(&r_perf_wait)) r_perf_wait <= r_perf_wait + 1'b1;
    end
  end

  assign o_perf_stall_cnt = rst ? '0 : r_perf_stall;
  assign o_perf_flush_cnt = rst ? '0 : r_perf_flush;
  assign o_perf_wait_cnt  = rst ? '0 : r_perf_wait;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected control vectors flow through a scoreboard queue.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic       ifid_use_rs1, ifid_use_rs2, idex_reg_en, idex_is_load;
  logic       exmem_reg_en, exmem_is_load, memwb_reg_en, dm_req, dm_ready, br_taken;
  logic       stall_if, stall_id, stall_ex, stall_mem, bubble_ex;
  logic       flush_ifid, flush_idex, bubble_wb, mem_err;
  logic [1:0] fwd_a, fwd_b;
  logic [12:0] obs;

  typedef struct {
    string       tag;
    logic [12:0] exp;
  } sb_t;
  sb_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.WAIT_TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_ifid_rs1(ifid_rs1), .i_ifid_rs2(ifid_rs2),
    .i_ifid_use_rs1(ifid_use_rs1), .i_ifid_use_rs2(ifid_use_rs2),
    .i_idex_rs1(idex_rs1), .i_idex_rs2(idex_rs2), .i_idex_rd(idex_rd),
    .i_idex_reg_en(idex_reg_en), .i_idex_is_load(idex_is_load),
    .i_exmem_rd(exmem_rd), .i_exmem_reg_en(exmem_reg_en), .i_exmem_is_load(exmem_is_load),
    .i_memwb_rd(memwb_rd), .i_memwb_reg_en(memwb_reg_en),
    .i_dm_req(dm_req), .i_dm_ready(dm_ready), .i_br_taken(br_taken),
    .o_stall_if(stall_if), .o_stall_id(stall_id), .o_stall_ex(stall_ex),
    .o_stall_mem(stall_mem), .o_bubble_ex(bubble_ex),
    .o_flush_ifid(flush_ifid), .o_flush_idex(flush_idex), .o_bubble_wb(bubble_wb),
    .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_mem_err(mem_err)
  );

  assign obs = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex,
                flush_ifid, flush_idex, bubble_wb, fwd_a, fwd_b, mem_err};

  // frz: full freeze, lu: load-use stall, fl: branch flush
  function automatic logic [12:0] ev(input logic frz, input logic lu, input logic fl,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic err);
    return {frz | lu, frz | lu, frz, frz, lu, fl, fl, frz, fa, fb, err};
  endfunction

  task automatic clr_in();
    {ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd} = '0;
    {ifid_use_rs1, ifid_use_rs2, idex_reg_en, idex_is_load} = '0;
    {exmem_reg_en, exmem_is_load, memwb_reg_en, dm_req, dm_ready, br_taken} = '0;
  endtask

  // Inputs are driven at a negedge; outputs are sampled 4 ns later, before the next posedge.
  task automatic step(input string tag, input logic [12:0] exp);
    sb_t e, got;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    #4;
    got = sb_q.pop_front();
    n_tests++;
    assert (obs === got.exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", got.tag, obs, got.exp);
      end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    clr_in();
    rst = 1'b1;
    dm_req = 1'b1; br_taken = 1'b1; memwb_reg_en = 1'b1;
    @(negedge clk);
    step("reset_quiet", ev(0, 0, 0, 2'b00, 2'b00, 0));
    rst = 1'b0;
    clr_in();
    step("idle", ev(0, 0, 0, 2'b00, 2'b00, 0));

    // Load-use on rs1, then forward from MEM/WB
    idex_is_load = 1; idex_reg_en = 1; idex_rd = 2; ifid_rs1 = 2; ifid_use_rs1 = 1;
    step("lu_rs1", ev(0, 1, 0, 2'b00, 2'b00, 0));
    clr_in();
    memwb_rd = 2; memwb_reg_en = 1; idex_rs1 = 2; idex_rs2 = 0;
    step("lu_fwd_wb", ev(0, 0, 0, 2'b10, 2'b00, 0));

    // use_rs gating and rs2 path
    clr_in();
    idex_is_load = 1; idex_reg_en = 1; idex_rd = 3;
    ifid_rs1 = 3; ifid_use_rs1 = 0; ifid_rs2 = 1; ifid_use_rs2 = 1;
    step("lu_unused_src", ev(0, 0, 0, 2'b00, 2'b00, 0));
    ifid_rs2 = 3;
    step("lu_rs2", ev(0, 1, 0, 2'b00, 2'b00, 0));
    idex_reg_en = 0;
    step("lu_no_regen", ev(0, 0, 0, 2'b00, 2'b00, 0));

    // Forward priority and register 0 forwardable
    clr_in();
    exmem_rd = 1; exmem_reg_en = 1; memwb_rd = 1; memwb_reg_en = 1; idex_rs2 = 1; idex_rs1 = 0;
    step("fwd_prio_mem", ev(0, 0, 0, 2'b00, 2'b01, 0));
    exmem_is_load = 1;
    step("fwd_load_to_wb", ev(0, 0, 0, 2'b00, 2'b10, 0));
    clr_in();
    exmem_rd = 0; exmem_reg_en = 1; memwb_rd = 3; memwb_reg_en = 1; idex_rs1 = 0; idex_rs2 = 3;
    step("fwd_r0_r3", ev(0, 0, 0, 2'b01, 2'b10, 0));

    // Flush beats load-use; next cycle the load-use stall appears
    clr_in();
    idex_is_load = 1; idex_reg_en = 1; idex_rd = 1; ifid_rs1 = 1; ifid_use_rs1 = 1;
    br_taken = 1;
    step("flush_over_lu", ev(0, 0, 1, 2'b00, 2'b00, 0));
    br_taken = 0;
    step("lu_after_flush", ev(0, 1, 0, 2'b00, 2'b00, 0));

    // Memory wait with branch during freeze
    clr_in();
    dm_req = 1;
    idex_is_load = 1; idex_reg_en = 1; idex_rd = 1; ifid_rs1 = 1; ifid_use_rs1 = 1;
    step("mw_enter", ev(1, 0, 0, 2'b00, 2'b00, 0));
    br_taken = 1;
    step("mw_br_frozen", ev(1, 0, 0, 2'b00, 2'b00, 0));
    br_taken = 0;
    step("mw_3", ev(1, 0, 0, 2'b00, 2'b00, 0));
    dm_ready = 1;
    step("mw_ready_flush", ev(0, 0, 1, 2'b00, 2'b00, 0));
    clr_in();
    step("mw_pend_cleared", ev(0, 0, 0, 2'b00, 2'b00, 0));

    // Timeout: one RUN freeze cycle, 16 MEM_WAIT cycles, then HALT
    dm_req = 1;
    step("to_enter", ev(1, 0, 0, 2'b00, 2'b00, 0));
    for (int i = 0; i < 16; i++)
      step($sformatf("to_wait%0d", i), ev(1, 0, 0, 2'b00, 2'b00, 0));
    step("halt", ev(1, 0, 0, 2'b00, 2'b00, 1));
    dm_req = 0; dm_ready = 1; br_taken = 1;
    step("halt_sticky", ev(1, 0, 0, 2'b00, 2'b00, 1));
    br_taken = 0; memwb_reg_en = 1; memwb_rd = 2; idex_rs2 = 2;
    step("halt_fwd", ev(1, 0, 0, 2'b00, 2'b10, 1));

    // Reset out of HALT
    clr_in();
    rst = 1;
    step("rst_in_halt", ev(0, 0, 0, 2'b00, 2'b00, 0));
    rst = 0;
    step("post_rst", ev(0, 0, 0, 2'b00, 2'b00, 0));
    idex_is_load = 1; idex_reg_en = 1; idex_rd = 0; ifid_rs2 = 0; ifid_use_rs2 = 1;
    step("post_rst_lu", ev(0, 1, 0, 2'b00, 2'b00, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
